// File: rtl/wiphase_top_level_cpu_v2_cpu_mult_seq_if.sv
// Operand/result bus of the sequential multiplier: the CPU side is the master,
// the multiplier is the slave.
interface wiphase_top_level_cpu_v2_cpu_mult_seq_if;
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic [1:0]  op;
    logic        start;
    logic [31:0] result;
    logic        done;
    logic        busy;

    modport master (
        output E_src1, E_src2, op, start,
        input  result, done, busy
    );

    modport slave (
        input  E_src1, E_src2, op, start,
        output result, done, busy
    );
endinterface

// File: rtl/wiphase_top_level_cpu_v2_cpu_mult_seq.sv
// Sequential 32x32 multiplier built from four 16x16 partial products through one
// registered multiplier; signed high-word variants are fixed up in a final step.
module wiphase_top_level_cpu_v2_cpu_mult_seq (
    input  logic clk,
    input  logic reset_n,
    input  logic M_en,
    wiphase_top_level_cpu_v2_cpu_mult_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CORR} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [31:0] a_reg, b_reg;
    logic [1:0]  op_reg;
    logic [31:0] mult_reg;
    logic [1:0]  term_reg;
    logic [63:0] acc_reg;
    logic [31:0] result_reg;

    logic        accept;
    logic        done_now;
    logic [15:0] mul_a, mul_b;
    logic [63:0] term_shifted;
    logic [31:0] corr_hi;
    logic [31:0] final_word;

    // The done cycle doubles as an idle cycle, so back-to-back starts are taken there.
    assign accept   = M_en && bus.start && (state_reg == IDLE || state_reg == CORR);
    assign done_now = M_en && (state_reg == CORR);

    assign bus.done   = done_now;
    assign bus.busy   = (state_reg == ISSUE) || (state_reg == DRAIN) ||
                        ((state_reg == CORR) && !M_en);
    assign bus.result = done_now ? final_word : result_reg;

    // Counter bit 1 picks the A half, bit 0 the B half: P0..P3 in order.
    assign mul_a = cnt_reg[1] ? a_reg[31:16] : a_reg[15:0];
    assign mul_b = cnt_reg[0] ? b_reg[31:16] : b_reg[15:0];

    always_comb begin
        term_shifted = 64'd0;
        case (term_reg)
            2'd0:    term_shifted = {32'd0, mult_reg};
            2'd3:    term_shifted = {mult_reg, 32'd0};
            default: term_shifted = {16'd0, mult_reg, 16'd0};
        endcase
    end

    // Unsigned product minus the 2^32-weighted sign terms of the signed operands.
    assign corr_hi = acc_reg[63:32]
                   - ((op_reg[1] && a_reg[31]) ? b_reg : 32'd0)
                   - (((op_reg == 2'b10) && b_reg[31]) ? a_reg : 32'd0);
    assign final_word = (op_reg == 2'b00) ? acc_reg[31:0] : corr_hi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (M_en) begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_next = ISSUE;
                        cnt_next   = 2'd0;
                    end
                end
                ISSUE: begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3)
                        state_next = DRAIN;
                end
                DRAIN: state_next = CORR;
                CORR: begin
                    cnt_next   = 2'd0;
                    state_next = accept ? ISSUE : IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            op_reg     <= 2'd0;
            mult_reg   <= 32'd0;
            term_reg   <= 2'd0;
            acc_reg    <= 64'd0;
            result_reg <= 32'd0;
        end else if (M_en) begin
            if (state_reg == ISSUE) begin
                mult_reg <= {16'd0, mul_a} * {16'd0, mul_b};
                term_reg <= cnt_reg;
            end
            // Each product lands in the accumulator one cycle after its issue.
            if ((state_reg == ISSUE && cnt_reg != 2'd0) || state_reg == DRAIN)
                acc_reg <= acc_reg + term_shifted;
            if (state_reg == CORR) begin
                acc_reg[63:32] <= corr_hi;
                result_reg     <= final_word;
            end
            if (accept) begin
                a_reg   <= bus.E_src1;
                b_reg   <= bus.E_src2;
                op_reg  <= bus.op;
                acc_reg <= 64'd0;
            end
        end
    end
endmodule

// File: tb/tb_wiphase_top_level_cpu_v2_cpu_mult_seq.sv
// Randomised and directed bench: stimulus pushes expectations on acceptance, an
// independent monitor checks timing, busy/done and result against a 64-bit model.
module tb_wiphase_top_level_cpu_v2_cpu_mult_seq;
    logic clk;
    logic reset_n;
    logic m_en;

    wiphase_top_level_cpu_v2_cpu_mult_seq_if bus();

    wiphase_top_level_cpu_v2_cpu_mult_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .M_en    (m_en),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pending;
    logic [31:0] exp_q[$];
    logic [31:0] last_result;
    bit          inflight;
    int          en_cnt;
    int          cycle;

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] o);
        logic [63:0] xa, xb, p;
        xa = (o == 2'b10 || o == 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (o == 2'b10) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, req);
        end
    endtask

    // Monitor: done is expected on the sixth enabled cycle after acceptance.
    always @(negedge clk) begin
        bit          exp_done, exp_busy;
        logic [31:0] want;
        cycle++;
        if (!reset_n) begin
            chk(bus.done == 1'b0, "rst_done", {31'd0, bus.done}, 32'd0);
            chk(bus.busy == 1'b0, "rst_busy", {31'd0, bus.busy}, 32'd0);
            chk(bus.result == 32'd0, "rst_result", bus.result, 32'd0);
            inflight    = 1'b0;
            en_cnt      = 0;
            last_result = 32'd0;
            exp_q.delete();
        end else begin
            if (inflight && m_en)
                en_cnt++;
            exp_done = inflight && m_en && (en_cnt == 6);
            exp_busy = inflight && !exp_done;
            chk(bus.done == exp_done, "done", {31'd0, bus.done}, {31'd0, exp_done});
            chk(bus.busy == exp_busy, "busy", {31'd0, bus.busy}, {31'd0, exp_busy});
            if (exp_done) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
                if (bus.done)
                    chk(bus.result === want, "result", bus.result, want);
                last_result = want;
                inflight    = 1'b0;
            end else if (!bus.done) begin
                chk(bus.result === last_result, "hold", bus.result, last_result);
            end
            if (bus.start && m_en && !exp_busy) begin
                exp_q.push_back(exp_pending);
                inflight = 1'b1;
                en_cnt   = 0;
            end
        end
    end

    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] o, input logic [31:0] e, input logic en);
        bus.start   = s;
        bus.E_src1  = a;
        bus.E_src2  = b;
        bus.op      = o;
        exp_pending = e;
        m_en        = en;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       input logic [31:0] e);
        drive(1'b1, a, b, o, e, 1'b1);
        repeat (6) drive(1'b0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b1);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFFFFFF;
            1:       return 32'h80000000;
            2:       return 32'h7FFFFFFF;
            3:       return 32'(($urandom_range(0, 1) != 0) ? 0 : 1);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        cycle       = 0;
        inflight    = 1'b0;
        en_cnt      = 0;
        last_result = 32'd0;
        reset_n     = 1'b0;
        m_en        = 1'b1;
        bus.start   = 1'b0;
        bus.E_src1  = 32'd0;
        bus.E_src2  = 32'd0;
        bus.op      = 2'd0;
        exp_pending = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed products with hand-derived results.
        run(32'h00010003, 32'h00020005, 2'b00, 32'h000B000F);
        run(32'h00010003, 32'h00020005, 2'b01, 32'h00000002);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'h00000000);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFF);
        run(32'h80000000, 32'h80000000, 2'b10, 32'h40000000);

        // 7 x 9 with a three-cycle stall in cycles 2..4.
        drive(1'b1, 32'd7, 32'd9, 2'b00, 32'h0000003F, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b1);
        repeat (3) drive(1'b0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b0);
        repeat (6) drive(1'b0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b1);

        // Back-to-back, with start held during busy carrying bogus operands.
        drive(1'b1, 32'd3, 32'd4, 2'b00, 32'h0000000C, 1'b1);
        repeat (5) drive(1'b1, $urandom, $urandom, 2'b01, 32'hDEADBEEF, 1'b1);
        run(32'd5, 32'd6, 2'b00, 32'h0000001E);

        // Reset in the middle of an operation, then an immediate new start.
        drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 2'b10, 32'hDEADBEEF, 1'b1);
        repeat (2) drive(1'b0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b1);
        reset_n = 1'b0;
        repeat (2) drive(1'b0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b1);
        reset_n = 1'b1;
        run(32'h0000FFFF, 32'h00010001, 2'b00, 32'hFFFFFFFF);
        drive(1'b0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b1);

        // Random sweep with random stalls and starts.
        for (int i = 0; i < 600; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            ro = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 2) == 0), ra, rb, ro, ref_mul(ra, rb, ro),
                  ($urandom_range(0, 3) != 0));
        end
        repeat (12) drive(1'b0, 32'd0, 32'd0, 2'd0, 32'd0, 1'b1);

        chk(!inflight && exp_q.size() == 0, "drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wiphase_top_level_cpu_v2_cpu_mult_seq.md
WIPHASE_TOP_LEVEL_CPU_V2_CPU_MULT_SEQ -- requirements
Module: wiphase_top_level_cpu_v2_cpu_mult_seq

Interface
REQ-001 SHALL have parameter: none; all widths fixed (32-bit operands, 16x16 internal multiplier).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 E_src1  input  32  operand A; sampled only on an accepted start.
REQ-005 E_src2  input  32  operand B; sampled only on an accepted start.
REQ-006 op  input  2  00 MUL (low word), 01 MULXUU (high, unsigned x unsigned), 10 MULXSS (high, signed x signed), 11 MULXSU (high, A signed x B unsigned); sampled with operands.
REQ-007 start  input  1  request; accepted when busy=0.
REQ-008 M_en  input  1  stall control; 0 freezes all internal state.
REQ-009 result  output  32  selected product word.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 busy  output  1  operation in progress; start ignored while high.

Function
REQ-012 SHALL compute the 64-bit product as four 16x16 unsigned partial products: P0=A[15:0]*B[15:0], P1=A[15:0]*B[31:16], P2=A[31:16]*B[15:0], P3=A[31:16]*B[31:16], through one shared multiplier with a registered output.
REQ-013 SHALL use states IDLE -> ISSUE (4 cycles, 2-bit counter 0..3 selecting P0..P3) -> DRAIN (1 cycle, last product accumulated) -> CORR (1 cycle) -> IDLE.
REQ-014 SHALL accumulate into a 64-bit register: acc += P0 + (P1<<16) + (P2<<16) + (P3<<32), each term added the cycle after its issue; acc cleared on start acceptance.
REQ-015 SHALL apply sign correction in CORR: acc[63:32] -= B if (op=10 or 11) and A[31]; acc[63:32] -= A if op=10 and B[31]; arithmetic modulo 2^32.
REQ-016 SHALL set result = acc[31:0] for op=00, acc[63:32] otherwise; result register updated only at the CORR->IDLE transition and held until the next done.
REQ-017 SHALL accept start at cycle 0 (busy=0, M_en=1); busy=1 in cycles 1..5; done=1 and busy=0 in cycle 6 (fixed latency 6 with M_en held 1, independent of op).
REQ-018 SHALL treat start accepted in the done cycle as a normal back-to-back request (next done 6 cycles later).
REQ-019 SHALL ignore start while busy=1; operands/op of the in-flight operation unaffected.
REQ-020 SHALL, while M_en=0, hold state, counter, multiplier register, accumulator, result; done is not emitted and start is not accepted; each stalled cycle adds one cycle of latency.
REQ-021 SHALL, if M_en=0 in the cycle done would assert, defer the done pulse to the first cycle M_en=1.

Reset
REQ-022 SHALL on reset_n=0 asynchronously force state IDLE, counter 0, acc 0, multiplier register 0, result 0x00000000, done 0, busy 0.
REQ-023 SHALL discard any in-flight operation on reset; no done pulse for it after reset release.
REQ-024 SHALL accept start in the first clock edge after reset_n deasserts.

Verification
REQ-025 MUL A=0x00010003 B=0x00020005, start cycle 0 -> done cycle 6, result 0x000B000F; op=01 same operands -> 0x00000002.
REQ-026 MULXUU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULXSS A=B=0xFFFFFFFF -> 0x00000000; MULXSU A=B=0xFFFFFFFF -> 0xFFFFFFFF; MULXSS A=B=0x80000000 -> 0x40000000.
REQ-027 MUL 7x9 with M_en=0 cycles 2..4 -> done cycle 9, result 0x0000003F, busy high cycles 1..8.
REQ-028 start accepted cycle 0, reset_n pulsed low cycle 3 -> result 0, busy 0, no done; new start after release completes with correct value in 6 cycles.
REQ-029 back-to-back: MUL 3x4 cycle 0, start asserted MUL 5x6 cycle 6 -> done cycles 6 (0x0000000C) and 12 (0x0000001E); start pulses during cycles 1..5 ignored.
REQ-030 random op/operand sweep with random M_en stalls -> result matches 64-bit reference model per op on every done.
